// File: rtl/feature_map_streamer.sv
// Raster streamer: reads one feature map from a sync buffer, emits it row-major.
// Define ROW_GAP_EN to insert ROW_GAP idle issue cycles between rows.
module feature_map_streamer #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 30,
  parameter int IMG_HEIGHT = 30,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int ROW_GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic                  Pause,
  output logic                  Mem_Rd_En,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  input  logic [DATA_WIDHT-1:0] Mem_Data,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Last_Out,
  output logic                  Busy,
  output logic                  Done
);

  localparam int CW = $clog2(IMG_WIDHT + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam int GW = $clog2(ROW_GAP + 2);

`ifdef ROW_GAP_EN
  localparam int GAP = ROW_GAP;
`else
  localparam int GAP = ROW_GAP * 0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic                    rd_v1_q, rd_v1_d;
  logic                    last1_q, last1_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [DATA_WIDHT-1:0]   data_q, data_d;

  logic                    rd_en;
  logic                    final_iss;
  logic                    row_end;
  logic                    frame_end;

  assign row_end   = (col_q == CW'(IMG_WIDHT - 1));
  assign frame_end = row_end && (row_q == RW'(IMG_HEIGHT - 1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    col_d     = col_q;
    row_d     = row_q;
    gap_d     = gap_q;
    rd_en     = 1'b0;
    final_iss = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_STREAM;
          addr_d  = ADDR_WIDTH'(BASE_ADDR);
          col_d   = '0;
          row_d   = '0;
          gap_d   = '0;
        end
      end
      S_STREAM: begin
        if (!Pause) begin
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else begin
            rd_en = 1'b1;
            if (frame_end) begin
              // address holds on the final pixel so it never passes the frame
              final_iss = 1'b1;
              state_d   = S_DRAIN;
            end else begin
              addr_d = addr_q + ADDR_WIDTH'(1);
              if (row_end) begin
                col_d = '0;
                row_d = row_q + RW'(1);
                gap_d = GW'(GAP);
              end else begin
                col_d = col_q + CW'(1);
              end
            end
          end
        end
      end
      S_DRAIN: begin
        // stage 2 empties on the same edge that stage 1 is seen empty
        if (!rd_v1_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_v1_d = rd_en;
    last1_d = final_iss;
    valid_d = rd_v1_q;
    last_d  = last1_q;
    data_d  = rd_v1_q ? Mem_Data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      rd_v1_q <= 1'b0;
      last1_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      rd_v1_q <= rd_v1_d;
      last1_q <= last1_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign Mem_Rd_En = rd_en;
  assign Mem_Addr  = addr_q;
  assign Data_Out  = data_q;
  assign Valid_Out = valid_q;
  assign Last_Out  = last_q && valid_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_feature_map_streamer.sv
// Directed bench for feature_map_streamer: 4x3 frame at base 20, data = 100+i.
// Covers plain, paused, restart-ignored, back-to-back and mid-frame reset frames.
module tb_feature_map_streamer;

  localparam int DW   = 32;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int AW   = 10;
  localparam int BASE = 20;
  localparam int RG   = 2;
  localparam int N    = W * H;

`ifdef ROW_GAP_EN
  localparam int G = RG;
`else
  localparam int G = 0;
`endif

  localparam int D0 = 3 + N + G * (H - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Start = 1'b0;
  logic          Pause = 1'b0;
  logic          Mem_Rd_En;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_Data;
  logic [DW-1:0] Data_Out;
  logic          Valid_Out;
  logic          Last_Out;
  logic          Busy;
  logic          Done;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;
  int nvalid;
  int ndone;

  feature_map_streamer #(
    .DATA_WIDHT(DW),
    .IMG_WIDHT (W),
    .IMG_HEIGHT(H),
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE),
    .ROW_GAP   (RG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .Pause    (Pause),
    .Mem_Rd_En(Mem_Rd_En),
    .Mem_Addr (Mem_Addr),
    .Mem_Data (Mem_Data),
    .Data_Out (Data_Out),
    .Valid_Out(Valid_Out),
    .Last_Out (Last_Out),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (Mem_Rd_En) Mem_Data <= mem[Mem_Addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // p0..p1: Pause window, xs: cycle of a stray Start, stop_c: last cycle run
  task automatic run_frame(input int p0, input int p1, input int xs,
                           input int done_c, input int stop_c);
    int  iss [0:127];
    int  k;
    int  gap;
    int  v;
    bit  pz;
    k = 0;
    gap = 0;
    for (int i = 0; i < 128; i++) iss[i] = -1;
    nvalid = 0;
    ndone = 0;
    @(posedge clk); #1;
    Start = 1'b1;
    Pause = 1'b0;
    @(negedge clk);
    chk("busy_c0", Busy, 0);
    for (int c = 1; c <= stop_c; c++) begin
      @(posedge clk); #1;
      pz = (c >= p0 && c <= p1);
      Start = (c == xs);
      Pause = pz;
      @(negedge clk);
      if (k < N && !pz) begin
        if (gap > 0) begin
          gap--;
        end else begin
          chk("rd_en", Mem_Rd_En, 1);
          chk("addr", Mem_Addr, BASE + k);
          iss[c] = k;
          k++;
          if (k % W == 0 && k < N) gap = G;
        end
      end
      if (iss[c] < 0) chk("rd_idle", Mem_Rd_En, 0);
      v = (c >= 3) ? iss[c-2] : -1;
      chk("valid", Valid_Out, v >= 0);
      if (v >= 0) begin
        chk("data", Data_Out, 100 + v);
        nvalid++;
      end
      chk("last", Last_Out, v == N - 1);
      chk("done", Done, c == done_c);
      if (Done) ndone++;
      chk("busy", Busy, c <= done_c);
    end
    Start = 1'b0;
    Pause = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hDEAD0000 + i;
    for (int i = 0; i < N; i++) mem[BASE+i] = 100 + i;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", Mem_Rd_En, 0);
    chk("rst_addr", Mem_Addr, 0);
    chk("rst_valid", Valid_Out, 0);
    chk("rst_last", Last_Out, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_data", Data_Out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(-1, -1, -1, D0, D0);
    chk("a_nvalid", nvalid, N);
    chk("a_ndone", ndone, 1);

    run_frame(4, 5, -1, D0 + 2, D0 + 2);
    chk("b_nvalid", nvalid, N);
    chk("b_ndone", ndone, 1);

    run_frame(-1, -1, 5, D0, D0 + 3);
    chk("c_nvalid", nvalid, N);
    chk("c_ndone", ndone, 1);

    run_frame(-1, -1, -1, D0, 7);
    chk("d_nvalid", nvalid, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", Valid_Out, 0);
    chk("mid_rst_last", Last_Out, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_rd", Mem_Rd_En, 0);
    chk("mid_rst_addr", Mem_Addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", Valid_Out, 0);
      chk("post_rst_rd", Mem_Rd_En, 0);
    end

    run_frame(-1, -1, -1, D0, D0);
    chk("e_nvalid", nvalid, N);
    chk("e_ndone", ndone, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/feature_map_streamer.md
Name: feature_map_streamer

Overview:
- Transmit end of the raster pixel stream consumed by the 3x3 stride-1 padded convolution blocks.
- On Start, reads one IMG_WIDHT x IMG_HEIGHT feature map from a synchronous on-chip buffer and emits it in row-major order, one pixel per cycle, on Data_Out/Valid_Out.
- Drives the convolution Data_In/Valid_In pair directly.
- Reports frame progress with Busy, Last_Out and Done.

Parameters:
- DATA_WIDHT, 32, pixel word width.
- IMG_WIDHT, 30, pixels per row.
- IMG_HEIGHT, 30, rows per frame.
- ADDR_WIDTH, 10, buffer address width; must satisfy 2^ADDR_WIDTH >= BASE_ADDR + IMG_WIDHT*IMG_HEIGHT.
- BASE_ADDR, 0, buffer address of pixel (row 0, col 0).
- ROW_GAP, 2, idle cycles inserted between rows; used only with ROW_GAP_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle frame start request; honoured only in IDLE.
- Pause  in  1  when high, no new buffer read is issued that cycle.
- Mem_Rd_En  out  1  buffer read strobe.
- Mem_Addr  out  ADDR_WIDTH  buffer read address.
- Mem_Data  in  DATA_WIDHT  buffer read data, valid the cycle after Mem_Rd_En.
- Data_Out  out  DATA_WIDHT  pixel to the convolution input.
- Valid_Out  out  1  Data_Out holds a valid pixel.
- Last_Out  out  1  high together with Valid_Out on the final pixel of the frame.
- Busy  out  1  frame in progress.
- Done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Reset values: all outputs 0, Mem_Addr = 0, state IDLE, row/col counters 0, pipeline valid flags 0.
- FSM states:
  - IDLE: Start=1 goes to STREAM; on the same edge the address counter loads BASE_ADDR and row/col load 0. Start while not IDLE is ignored.
  - STREAM: in each cycle with Pause=0 (and no gap active), assert Mem_Rd_En, drive Mem_Addr = current address, then advance. Advance means address+1 and col+1; at col = IMG_WIDHT-1, col wraps to 0 and row+1. Issuing pixel (IMG_HEIGHT-1, IMG_WIDHT-1) goes to DRAIN.
  - With Pause=1: Mem_Rd_En=0 and counters hold.
  - DRAIN: no reads; wait until both pipeline stages are empty, then go to DONE.
  - DONE: Done=1 for one cycle, then IDLE.
- Busy = 1 in STREAM, DRAIN and DONE; 0 in IDLE.
- Pipeline:
  - Read issued at cycle t; Mem_Data sampled at t+1 into Data_Out.
  - Valid_Out=1 at t+2, so fixed latency is 2 cycles from Mem_Rd_En to Valid_Out.
  - Valid_Out tracks a delayed copy of Mem_Rd_En, so Pause creates bubbles (Valid_Out=0) with identical pixel order.
- Data_Out holds its last value while Valid_Out=0.
- Last_Out is a delayed copy of the "final issue" flag and is never high without Valid_Out.
- Timing without Pause: Start at cycle 0 gives first Valid_Out at cycle 3, the last at cycle 2+N with N = IMG_WIDHT*IMG_HEIGHT, and Done at cycle 3+N.
- Pause in DRAIN has no effect, because all reads are already issued.
- Reset mid-frame: the frame is aborted immediately. Valid_Out, Last_Out and Done stay 0 until a new Start; no stale pixel is emitted.
- Address arithmetic is unsigned and never exceeds BASE_ADDR+N-1.

Optional Feature:
- Macro: ROW_GAP_EN.
- Defined: after issuing the last pixel of each row except the final row, the streamer waits exactly ROW_GAP non-paused cycles with Mem_Rd_En=0 before issuing the next row. Cycles with Pause=1 do not count toward the gap. This gives downstream line buffers row-turnaround time. Done moves later by ROW_GAP*(IMG_HEIGHT-1) cycles.
- Undefined: rows are issued back-to-back and the ROW_GAP parameter is unused.

Test Plan:
- Basic frame: IMG_WIDHT=4, IMG_HEIGHT=3, BASE_ADDR=0, buffer[i]=i+100, Start at cycle 0 -> Valid_Out cycles 3..14 carry 100..111 in order; Last_Out only with 111; Done=1 only at cycle 15; Busy 1 for cycles 1..15.
- Pause: same frame, Pause=1 at cycles 4-5 -> exactly two Valid_Out bubbles; sequence still 100..111 with no repeats or skips; Done at cycle 17.
- Base offset and ignored Start: BASE_ADDR=20, Start re-pulsed mid-frame -> Mem_Addr spans 20..31 exactly once; second Start ignored; one Done.
- Reset mid-frame: rst asserted after the 5th Valid_Out -> all outputs 0 within the reset cycle; no Valid_Out until the next Start; next frame restarts at 100.
- Back-to-back frames: Start in the cycle after Done -> second frame identical to the first, with first Valid_Out 3 cycles after that Start.
- ROW_GAP_EN, ROW_GAP=2: 4x3 frame -> 2-cycle Valid_Out gaps after pixels 103 and 107 only; Done at cycle 19.
